obi_rr_arbiter: RTL

OBI_RR_ARBITER -- requirements
Module: obi_rr_arbiter

---
 rtl/obi_rr_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/obi_rr_arbiter.sv
// obi_rr_arbiter: two primary OBI ports arbitrated round-robin onto one secondary OBI port.
// Latency: request to sec_req_o one cycle; secondary grant and response reach the owner combinationally.
// Backpressure: one transaction at a time; primaries see no gnt until the secondary grants the owner's request.
module obi_rr_arbiter #(
  parameter int unsigned RVALID_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        p0_req_i,
  output logic        p0_gnt_o,
  input  logic [31:0] p0_addr_i,
  input  logic        p0_we_i,
  input  logic [3:0]  p0_be_i,
  input  logic [31:0] p0_wdata_i,
  output logic        p0_rvalid_o,
  output logic [31:0] p0_rdata_o,
  input  logic        p1_req_i,
  output logic        p1_gnt_o,
  input  logic [31:0] p1_addr_i,
  input  logic        p1_we_i,
  input  logic [3:0]  p1_be_i,
  input  logic [31:0] p1_wdata_i,
  output logic        p1_rvalid_o,
  output logic [31:0] p1_rdata_o,
  output logic        sec_req_o,
  output logic [31:0] sec_addr_o,
  output logic        sec_we_o,
  output logic [3:0]  sec_be_o,
  output logic [31:0] sec_wdata_o,
  input  logic        sec_gnt_i,
  input  logic        sec_rvalid_i,
  input  logic [31:0] sec_rdata_i,
  output logic        busy_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  // Timeout fires in the RESP cycle whose missing rvalid would bring the count to RVALID_TIMEOUT.
  localparam logic [15:0] CNT_LAST = 16'(RVALID_TIMEOUT - 1);

  state_t      state;
  logic        owner;     // port that owns the outstanding transaction
  logic        last_gnt;  // port that won the most recent arbitration
  logic [15:0] rsp_cnt;

  logic        any_req;
  logic        winner;
  logic        gnt_hit;
  logic        rsp_hit;
  logic        tmo_hit;
  logic        rv_hit;
  logic [31:0] rdata_sel;

  // Round-robin pick: on contention the port not granted last wins, otherwise the lone requester.
  always_comb begin
    any_req = p0_req_i | p1_req_i;
    if (p0_req_i && p1_req_i) begin
      winner = ~last_gnt;
    end else begin
      winner = p1_req_i;
    end
  end

  // Grant, response and timeout events for the current cycle; all silenced while reset is held.
  always_comb begin
    gnt_hit   = !rst_i && (state == REQ) && sec_gnt_i;
    rsp_hit   = !rst_i && (state == RESP) && sec_rvalid_i;
    tmo_hit   = !rst_i && (state == RESP) && !sec_rvalid_i && (rsp_cnt == CNT_LAST);
    rv_hit    = rsp_hit | tmo_hit;
    rdata_sel = tmo_hit ? 32'hFFFF_FFFF : sec_rdata_i;
  end

  assign p0_gnt_o    = gnt_hit & ~owner;
  assign p1_gnt_o    = gnt_hit & owner;
  assign p0_rvalid_o = rv_hit & ~owner;
  assign p1_rvalid_o = rv_hit & owner;
  assign p0_rdata_o  = (rv_hit && !owner) ? rdata_sel : 32'h0;
  assign p1_rdata_o  = (rv_hit && owner) ? rdata_sel : 32'h0;
  assign busy_o      = (state != IDLE);
  assign timeout_o   = tmo_hit;

  // Transaction FSM: arbitrate in IDLE, hold the request in REQ, wait for response or timeout in RESP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_gnt    <= 1'b1;
      rsp_cnt     <= 16'h0;
      sec_req_o   <= 1'b0;
      sec_addr_o  <= 32'h0;
      sec_we_o    <= 1'b0;
      sec_be_o    <= 4'h0;
      sec_wdata_o <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state       <= REQ;
            owner       <= winner;
            last_gnt    <= winner;
            sec_req_o   <= 1'b1;
            sec_addr_o  <= winner ? p1_addr_i : p0_addr_i;
            sec_we_o    <= winner ? p1_we_i : p0_we_i;
            sec_be_o    <= winner ? p1_be_i : p0_be_i;
            sec_wdata_o <= winner ? p1_wdata_i : p0_wdata_i;
          end
        end
        REQ: begin
          if (sec_gnt_i) begin
            state     <= RESP;
            sec_req_o <= 1'b0;
            rsp_cnt   <= 16'h0;
          end
        end
        RESP: begin
          if (sec_rvalid_i || (rsp_cnt == CNT_LAST)) begin
            state <= IDLE;
          end else begin
            rsp_cnt <= rsp_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
